// File: rtl/io_arb_pkg.sv
// rtl/io_arb_pkg.sv - shared types and helpers for the user I/O bank arbiter
package io_arb_pkg;

    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

    // Round-robin successor of the current owner, wrapping at nreq.
    function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] cur, input int nreq);
        logic [OWNER_W-1:0] nxt;
        if (int'(cur) >= nreq - 1) begin
            nxt = '0;
        end else begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder starting at a pointer
import io_arb_pkg::*;

module rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    req_i,
    input  logic [OWNER_W-1:0] start_i,
    output logic [OWNER_W-1:0] winner_o,
    output logic               valid_o
);

    logic [NREQ-1:0]  req_rot;
    logic [OWNER_W:0] sum;

    // Rotate so bit 0 is the start pointer; the first set bit is the winner.
    assign req_rot = NREQ'({req_i, req_i} >> start_i);

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid_o && req_rot[i]) begin
                valid_o = 1'b1;
                sum     = {1'b0, start_i} + (OWNER_W+1)'(i);
                if (sum >= (OWNER_W+1)'(NREQ)) begin
                    sum = sum - (OWNER_W+1)'(NREQ);
                end
                winner_o = sum[OWNER_W-1:0];
            end
        end
    end

endmodule

// File: rtl/io_bank_arbiter.sv
// rtl/io_bank_arbiter.sv - round-robin owner arbiter for the user I/O output bank
import io_arb_pkg::*;

module io_bank_arbiter #(
    parameter int               NREQ       = 3,
    parameter int               WIDTH      = 8,
    parameter int               HOLD_MAX   = 1024,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         rel_i,
    input  logic [NREQ*WIDTH-1:0]   data_i,
    input  logic [NREQ*WIDTH-1:0]   oe_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [OWNER_W-1:0]      owner_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic [WIDTH-1:0]        io_out,
    output logic [WIDTH-1:0]        io_oeb
);

    localparam int HCNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HCNT_W'(HOLD_MAX - 1) : '0;

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [HCNT_W-1:0]  hold_q, hold_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               timeout_q, timeout_d;
    logic [WIDTH-1:0]   io_out_q, io_out_d;
    logic [WIDTH-1:0]   io_oeb_q, io_oeb_d;

    logic [OWNER_W-1:0] pick_idx;
    logic               pick_valid;
    logic               own_req, own_rel;
    logic [WIDTH-1:0]   own_data, own_oe;
    logic               hold_expired, own_exit;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_i    (req_i),
        .start_i  (rr_ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // Only the current owner's lane is ever looked at.
    always_comb begin
        own_req  = 1'b0;
        own_rel  = 1'b0;
        own_data = '0;
        own_oe   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == OWNER_W'(k)) begin
                own_req  = req_i[k];
                own_rel  = rel_i[k];
                own_data = data_i[k*WIDTH +: WIDTH];
                own_oe   = oe_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign hold_expired = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
    assign own_exit     = own_rel || !own_req || hold_expired;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        gnt_d     = '0;
        timeout_d = 1'b0;
        io_out_d  = IDLE_VALUE;
        io_oeb_d  = '1;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_TURN;
                    owner_d = pick_idx;
                end
            end
            ST_TURN: begin
                state_d = ST_OWN;
                hold_d  = '0;
                gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
            end
            ST_OWN: begin
                if (own_exit) begin
                    // Pads and grant are released on the same edge the owner leaves.
                    state_d   = ST_IDLE;
                    rr_ptr_d  = rr_next(owner_q, NREQ);
                    timeout_d = hold_expired && own_req && !own_rel;
                end else begin
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                    io_out_d = own_data;
                    io_oeb_d = ~own_oe;
                    if (HOLD_MAX != 0) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            io_out_q  <= IDLE_VALUE;
            io_oeb_q  <= '1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            io_out_q  <= io_out_d;
            io_oeb_q  <= io_oeb_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q == ST_OWN);
    assign timeout_o = timeout_q;
    assign io_out    = io_out_q;
    assign io_oeb    = io_oeb_q;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// tb/tb_io_bank_arbiter.sv - self-checking bench for io_bank_arbiter
module tb_io_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_i;
    logic [2:0]  rel_i;
    logic [23:0] data_i;
    logic [23:0] oe_i;
    logic [2:0]  gnt_o;
    logic [2:0]  owner_o;
    logic        busy_o;
    logic        timeout_o;
    logic [7:0]  io_out;
    logic [7:0]  io_oeb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        logic [23:0] oe;
        int          owner;
        logic [7:0]  out;
        logic [7:0]  oeb;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic [7:0] oeb;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    io_bank_arbiter #(
        .NREQ       (3),
        .WIDTH      (8),
        .HOLD_MAX   (16),
        .IDLE_VALUE (8'h00)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_i     (req_i),
        .rel_i     (rel_i),
        .data_i    (data_i),
        .oe_i      (oe_i),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string name);
        int g;
        g = 0;
        while (gnt_o == 3'b000 && g < 20) begin
            tick();
            g++;
        end
        check(name, (g < 20) ? 1 : 0, 1);
    endtask

    initial begin
        exp_t e;
        int   ff_cnt;
        int   own_cnt;
        int   guard;
        int   exp_own;

        vecs[0] = '{3'b001, {8'h11, 8'h22, 8'hA5}, 24'hFFFFFF, 0, 8'hA5, 8'h00};
        vecs[1] = '{3'b010, {8'h33, 8'h3C, 8'h44}, {8'hFF, 8'h0F, 8'hFF}, 1, 8'h3C, 8'hF0};
        vecs[2] = '{3'b101, {8'h5A, 8'h66, 8'h77}, {8'hF0, 8'h00, 8'hFF}, 2, 8'h5A, 8'h0F};
        vecs[3] = '{3'b110, {8'h99, 8'hC3, 8'h88}, {8'h00, 8'hFF, 8'h00}, 1, 8'hC3, 8'h00};
        vecs[4] = '{3'b011, {8'hAA, 8'hBB, 8'h81}, {8'hFF, 8'hFF, 8'h55}, 0, 8'h81, 8'hAA};
        vecs[5] = '{3'b111, {8'hCC, 8'h7E, 8'hDD}, {8'hFF, 8'h00, 8'hFF}, 1, 8'h7E, 8'hFF};

        rst    = 1'b1;
        req_i  = '0;
        rel_i  = '0;
        data_i = '0;
        oe_i   = '0;
        tick();
        tick();
        check("rst_gnt", gnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_io_out", io_out, 8'h00);
        check("rst_io_oeb", io_oeb, 8'hFF);
        rst = 1'b0;
        tick();

        // Table-driven grants from IDLE; rr pointer carries between vectors.
        for (int v = 0; v < 6; v++) begin
            data_i = vecs[v].data;
            oe_i   = vecs[v].oe;
            req_i  = vecs[v].req;
            sb.push_back('{vecs[v].out, vecs[v].oeb});
            tick();
            check($sformatf("v%0d_turn_gnt", v), gnt_o, 0);
            check($sformatf("v%0d_turn_oeb", v), io_oeb, 8'hFF);
            tick();
            check($sformatf("v%0d_gnt", v), gnt_o, 32'(1) << vecs[v].owner);
            check($sformatf("v%0d_owner", v), owner_o, vecs[v].owner);
            check($sformatf("v%0d_busy", v), busy_o, 1);
            check($sformatf("v%0d_first_oeb", v), io_oeb, 8'hFF);
            tick();
            e = sb.pop_front();
            check($sformatf("v%0d_io_out", v), io_out, e.out);
            check($sformatf("v%0d_io_oeb", v), io_oeb, e.oeb);
            rel_i = 3'(1 << vecs[v].owner);
            tick();
            rel_i = '0;
            req_i = '0;
            check($sformatf("v%0d_rel_gnt", v), gnt_o, 0);
            check($sformatf("v%0d_rel_oeb", v), io_oeb, 8'hFF);
            check($sformatf("v%0d_rel_out", v), io_out, 8'h00);
            check($sformatf("v%0d_rel_busy", v), busy_o, 0);
            tick();
        end

        // Round-robin handover: all request, each releases 4 cycles after grant.
        do_reset();
        oe_i   = 24'hFFFFFF;
        data_i = {8'h03, 8'h02, 8'h01};
        req_i  = 3'b111;
        ff_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            exp_own = (r == 3) ? 0 : r;
            guard = 0;
            while (gnt_o == 3'b000 && guard < 20) begin
                if (io_oeb == 8'hFF) ff_cnt++;
                tick();
                guard++;
            end
            check($sformatf("rr%0d_gnt", r), gnt_o, 32'(1) << exp_own);
            check($sformatf("rr%0d_tristate", r), (ff_cnt >= 2) ? 1 : 0, 1);
            tick();
            check($sformatf("rr%0d_io_out", r), io_out, exp_own + 1);
            tick();
            tick();
            rel_i = 3'(1 << exp_own);
            tick();
            rel_i  = '0;
            ff_cnt = 0;
        end
        req_i = '0;
        tick();
        tick();

        // Hold timeout with HOLD_MAX=16.
        do_reset();
        data_i = '0;
        oe_i   = 24'hFFFFFF;
        req_i  = 3'b100;
        wait_gnt("to_wait1");
        check("to_gnt2", gnt_o, 3'b100);
        req_i   = 3'b101;
        own_cnt = 0;
        guard   = 0;
        while (busy_o && guard < 100) begin
            own_cnt++;
            tick();
            guard++;
        end
        check("to_own_cycles", own_cnt, 16);
        check("to_pulse", timeout_o, 1);
        check("to_gnt_drop", gnt_o, 0);
        tick();
        check("to_pulse_end", timeout_o, 0);
        wait_gnt("to_wait2");
        check("to_next_gnt", gnt_o, 3'b001);
        // Release on the last allowed cycle suppresses the timeout pulse.
        for (int i = 0; i < 15; i++) tick();
        check("to_last_busy", busy_o, 1);
        rel_i = 3'b001;
        tick();
        rel_i = '0;
        req_i = '0;
        check("to_rel_no_pulse", timeout_o, 0);
        check("to_rel_busy", busy_o, 0);
        tick();
        tick();

        // Non-owner release and data noise must not reach the pads.
        do_reset();
        oe_i  = 24'hFFFFFF;
        req_i = 3'b001;
        wait_gnt("nz_wait");
        check("nz_gnt", gnt_o, 3'b001);
        req_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            data_i = {8'($urandom), 8'($urandom), 8'(8'h10 + i)};
            rel_i  = 3'b110;
            sb.push_back('{8'(8'h10 + i), 8'h00});
            tick();
            e = sb.pop_front();
            check($sformatf("nz%0d_io_out", i), io_out, e.out);
            check($sformatf("nz%0d_gnt", i), gnt_o, 3'b001);
        end
        rel_i = 3'b001;
        tick();
        rel_i = '0;
        req_i = '0;
        tick();

        // Reset mid-grant clears the rr pointer (currently 1).
        req_i = 3'b011;
        wait_gnt("rs_wait1");
        check("rs_pre_gnt", gnt_o, 3'b010);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rs_gnt", gnt_o, 0);
        check("rs_oeb", io_oeb, 8'hFF);
        check("rs_out", io_out, 8'h00);
        check("rs_busy", busy_o, 0);
        check("rs_owner", owner_o, 0);
        rst = 1'b0;
        wait_gnt("rs_wait2");
        check("rs_first_gnt", gnt_o, 3'b001);
        req_i = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
